// File: rtl/wb_bus_pkg.sv
// Shared types and constants for the user-project Wishbone transaction controller.
package wb_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DECODE  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MADR_W   = 16;
    localparam int unsigned SLOT_LSB = 16;
    localparam int unsigned SLOT_W   = 4;
    localparam int unsigned WIN_LSB  = 20;
    localparam int unsigned WIN_W    = 12;
    localparam int unsigned CNT_W    = 16;

endpackage

// File: rtl/wb_timeout_counter.sv
// Per-access cycle counter; flags the cycle on which a slot has used up its ack budget.
module wb_timeout_counter
    import wb_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter holds (cycles spent in access - 1), so this fires on the TIMEOUT-th cycle.
    assign expired_c_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_bus_ctrl.sv
// Decodes management-side Wishbone requests onto N_SLAVES peripheral slots, one outstanding
// access at a time, terminating unmapped or hung accesses with an error response.
module wb_bus_ctrl
    import wb_bus_pkg::*;
#(
    parameter int unsigned N_SLAVES  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic [31:0]                wbs_dat_o,
    output logic                       wbs_ack_o,
    output logic [N_SLAVES-1:0]        m_cyc_o,
    output logic [N_SLAVES-1:0]        m_stb_o,
    output logic                       m_we_o,
    output logic [3:0]                 m_sel_o,
    output logic [15:0]                m_adr_o,
    output logic [31:0]                m_dat_o,
    input  logic [32*N_SLAVES-1:0]     m_dat_i,
    input  logic [N_SLAVES-1:0]        m_ack_i,
    input  logic                       err_clr_i,
    output logic                       err_o,
    output logic [1:0]                 err_code_o,
    output logic                       err_irq_o
);

    state_e                state_q;
    logic [SLOT_W-1:0]     slot_q;
    logic [N_SLAVES-1:0]   m_stb_q;
    logic                  m_we_q;
    logic [3:0]            m_sel_q;
    logic [MADR_W-1:0]     m_adr_q;
    logic [DATA_W-1:0]     m_dat_q;
    logic                  wbs_ack_q;
    logic [DATA_W-1:0]     wbs_dat_q;
    logic                  err_q;
    logic [1:0]            err_code_q;
    logic                  err_irq_q;

    logic [SLOT_W-1:0]     slot_c;
    logic                  req_c;
    logic                  hit_c;
    logic [N_SLAVES-1:0]   slot_oh_c;
    logic [DATA_W-1:0]     rdata_c;
    logic                  ack_sel_c;
    logic                  expired_c;

    assign slot_c = wbs_adr_i[SLOT_LSB +: SLOT_W];
    assign req_c  = wbs_cyc_i & wbs_stb_i;
    assign hit_c  = (wbs_adr_i[WIN_LSB +: WIN_W] == BASE_ADDR[WIN_LSB +: WIN_W])
                 && (32'(slot_c) < N_SLAVES);

    // Request slot one-hot, and read data / ack muxed from the slot already in flight.
    always_comb begin
        slot_oh_c = '0;
        rdata_c   = '0;
        ack_sel_c = 1'b0;
        for (int k = 0; k < int'(N_SLAVES); k++) begin
            slot_oh_c[k] = (slot_c == SLOT_W'(k));
            if (slot_q == SLOT_W'(k)) begin
                rdata_c   = m_dat_i[32*k +: 32];
                ack_sel_c = m_ack_i[k];
            end
        end
    end

    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk_i       (wb_clk_i),
        .rst_ni      (wb_rst_ni),
        .clr_i       (state_q != ST_ACCESS),
        .en_i        (state_q == ST_ACCESS),
        .expired_c_o (expired_c)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            m_stb_q    <= '0;
            m_we_q     <= 1'b0;
            m_sel_q    <= '0;
            m_adr_q    <= '0;
            m_dat_q    <= '0;
            wbs_ack_q  <= 1'b0;
            wbs_dat_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_irq_q  <= 1'b0;
        end else begin
            wbs_ack_q <= 1'b0;
            wbs_dat_q <= '0;
            err_irq_q <= 1'b0;
            // A new error later in this block overrides the clear.
            if (err_clr_i) begin
                err_q      <= 1'b0;
                err_code_q <= ERR_NONE;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req_c) begin
                        m_we_q  <= wbs_we_i;
                        m_sel_q <= wbs_sel_i;
                        m_adr_q <= wbs_adr_i[MADR_W-1:0];
                        m_dat_q <= wbs_dat_i;
                        slot_q  <= slot_c;
                        if (hit_c) begin
                            m_stb_q <= slot_oh_c;
                            state_q <= ST_ACCESS;
                        end else begin
                            wbs_ack_q  <= 1'b1;
                            wbs_dat_q  <= ERR_DATA;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_DECODE;
                            err_irq_q  <= 1'b1;
                            state_q    <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!wbs_cyc_i) begin
                        m_stb_q <= '0;
                        state_q <= ST_IDLE;
                    end else if (ack_sel_c) begin
                        m_stb_q   <= '0;
                        wbs_ack_q <= 1'b1;
                        wbs_dat_q <= m_we_q ? '0 : rdata_c;
                        state_q   <= ST_RESP;
                    end else if (expired_c) begin
                        m_stb_q    <= '0;
                        wbs_ack_q  <= 1'b1;
                        wbs_dat_q  <= ERR_DATA;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        err_irq_q  <= 1'b1;
                        state_q    <= ST_RESP;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wbs_dat_o  = wbs_dat_q;
    assign wbs_ack_o  = wbs_ack_q;
    assign m_cyc_o    = m_stb_q;
    assign m_stb_o    = m_stb_q;
    assign m_we_o     = m_we_q;
    assign m_sel_o    = m_sel_q;
    assign m_adr_o    = m_adr_q;
    assign m_dat_o    = m_dat_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign err_irq_o  = err_irq_q;

endmodule

// File: tb/tb_wb_bus_ctrl.sv
// Randomized bench for wb_bus_ctrl: each transaction's outcome is predicted from its address,
// slot ack delay and abort cycle, then compared cycle by cycle against the DUT.
module tb_wb_bus_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned T = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic          clk;
    logic          rst_n;
    logic          stb, cyc, we;
    logic [3:0]    sel;
    logic [31:0]   adr, wdat;
    logic [31:0]   rdat_o;
    logic          ack_o;
    logic [N-1:0]  m_cyc, m_stb;
    logic          m_we;
    logic [3:0]    m_sel;
    logic [15:0]   m_adr;
    logic [31:0]   m_dat;
    logic [32*N-1:0] m_dat_i;
    logic [N-1:0]  m_ack_i;
    logic          err_clr;
    logic          err;
    logic [1:0]    err_code;
    logic          err_irq;

    int n_tests = 0;
    int n_fail  = 0;
    logic       err_m;
    logic [1:0] code_m;

    wb_bus_ctrl #(
        .N_SLAVES  (N),
        .BASE_ADDR (32'h3000_0000),
        .TIMEOUT   (T),
        .ERR_DATA  (ERRD)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_dat_o  (rdat_o),
        .wbs_ack_o  (ack_o),
        .m_cyc_o    (m_cyc),
        .m_stb_o    (m_stb),
        .m_we_o     (m_we),
        .m_sel_o    (m_sel),
        .m_adr_o    (m_adr),
        .m_dat_o    (m_dat),
        .m_dat_i    (m_dat_i),
        .m_ack_i    (m_ack_i),
        .err_clr_i  (err_clr),
        .err_o      (err),
        .err_code_o (err_code),
        .err_irq_o  (err_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_stb"}, 32'(m_stb), 32'd0);
        check_eq({tag, "_cyc"}, 32'(m_cyc), 32'd0);
        check_eq({tag, "_ack"}, 32'(ack_o), 32'd0);
        check_eq({tag, "_dat"}, rdat_o, 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_code"}, 32'(err_code), 32'd0);
        check_eq({tag, "_irq"}, 32'(err_irq), 32'd0);
        check_eq({tag, "_madr"}, 32'(m_adr), 32'd0);
        check_eq({tag, "_mdat"}, m_dat, 32'd0);
        check_eq({tag, "_msel"}, 32'(m_sel), 32'd0);
        check_eq({tag, "_mwe"}, 32'(m_we), 32'd0);
    endtask

    // d: slot ack delay after strobe (-1 = never); abort_at: cycle with cyc low (-1 = none);
    // clr0: pulse err_clr alongside the request.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int d, input int abort_at, input logic clr0);
        int slot, stb_end, ack_cyc, last, end_n;
        logic hit, errf, aborted, timed_out;
        logic [1:0] code;
        logic [31:0] exp_dat, exp_stb;
        logic [3:0] oh;
        slot    = int'(a[19:16]);
        hit     = (a[31:20] == 12'h300) && (slot < int'(N));
        oh      = hit ? 4'(1 << slot) : 4'b0;
        aborted = 1'b0;
        if (!hit) begin
            stb_end = 0; ack_cyc = 1; errf = 1'b1; code = 2'd1; exp_dat = ERRD;
        end else begin
            timed_out = !(d >= 0 && d + 1 <= int'(T));
            end_n     = timed_out ? int'(T) : d + 1;
            aborted   = (abort_at >= 1 && abort_at <= end_n);
            stb_end   = aborted ? abort_at : end_n;
            ack_cyc   = aborted ? -1 : end_n + 1;
            errf      = timed_out;
            code      = timed_out ? 2'd2 : 2'd0;
            exp_dat   = timed_out ? ERRD : (w ? 32'd0 : rd);
        end
        last = aborted ? stb_end + 1 : ack_cyc + 1;

        @(negedge clk);
        check_eq("idle_stb", 32'(m_stb), 32'd0);
        check_eq("idle_ack", 32'(ack_o), 32'd0);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = wd;
        err_clr = clr0;
        m_ack_i = 4'($urandom) & ~oh;
        m_dat_i = {$urandom, $urandom, $urandom, $urandom};

        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1 && clr0) begin err_m = 1'b0; code_m = 2'd0; end
            if (c == ack_cyc && errf) begin err_m = 1'b1; code_m = code; end
            exp_stb = (c <= stb_end) ? 32'(oh) : 32'd0;
            check_eq("stb", 32'(m_stb), exp_stb);
            check_eq("cyc", 32'(m_cyc), exp_stb);
            check_eq("ack", 32'(ack_o), 32'(c == ack_cyc));
            check_eq("rdata", rdat_o, (c == ack_cyc) ? exp_dat : 32'd0);
            check_eq("irq", 32'(err_irq), 32'(c == ack_cyc && errf));
            check_eq("err", 32'(err), 32'(err_m));
            check_eq("code", 32'(err_code), 32'(code_m));
            if (c <= stb_end) begin
                check_eq("m_adr", 32'(m_adr), 32'(a[15:0]));
                check_eq("m_sel", 32'(m_sel), 32'(s));
                check_eq("m_dat", m_dat, wd);
                check_eq("m_we", 32'(m_we), 32'(w));
            end
            err_clr = 1'b0;
            m_ack_i = 4'($urandom) & ~oh;
            m_dat_i = {$urandom, $urandom, $urandom, $urandom};
            if (hit && d >= 0 && c == d + 1) begin
                m_ack_i[slot] = 1'b1;
                m_dat_i[32*slot +: 32] = rd;
            end
            if ((aborted && c == stb_end) || c == ack_cyc) begin
                cyc = 1'b0; stb = 1'b0;
            end
        end
        m_ack_i = '0;
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        err_m = 1'b0; code_m = 2'd0;
        check_eq("clr_err", 32'(err), 32'd0);
        check_eq("clr_code", 32'(err_code), 32'd0);
        check_eq("clr_irq", 32'(err_irq), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
        m_dat_i = '0; m_ack_i = '0; err_clr = 1'b0;
        err_m = 1'b0; code_m = 2'd0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        do_txn(32'h3002_0010, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 0, -1, 1'b0);
        do_txn(32'h3000_0004, 1'b1, 4'b0011, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 3, -1, 1'b0);
        do_txn(32'h3007_0000, 1'b0, 4'hF, 32'h0, 32'h1111_1111, 0, -1, 1'b0);
        do_txn(32'h4000_0000, 1'b0, 4'hF, 32'h0, 32'h2222_2222, 0, -1, 1'b1);
        do_txn(32'h3001_0020, 1'b0, 4'hF, 32'h0, 32'h0, -1, -1, 1'b0);
        clear_err();
        do_txn(32'h3003_0000, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, int'(T) - 1, -1, 1'b0);
        do_txn(32'h3001_0000, 1'b0, 4'hF, 32'h0, 32'h0, -1, 3, 1'b0);
        do_txn(32'h3002_0000, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 1, -1, 1'b0);

        // Reset asserted while a hung access is in flight.
        do_txn(32'h3006_0000, 1'b0, 4'hF, 32'h0, 32'h0, 0, -1, 1'b0);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3001_0040; wdat = 32'h5555_AAAA;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_stb", 32'(m_stb), 32'h2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        err_m = 1'b0; code_m = 2'd0;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(32'h3001_0044, 1'b0, 4'hF, 32'h0, 32'h7654_3210, 2, -1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [11:0] win;
            logic [31:0] a;
            int d, ab;
            win = ($urandom_range(0, 9) == 0) ? 12'h400 : 12'h300;
            a   = {win, 4'($urandom_range(0, 5)), 16'($urandom)};
            d   = int'($urandom_range(0, 11)) - 1;
            ab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : -1;
            do_txn(a, 1'($urandom), 4'($urandom), $urandom, $urandom, d, ab,
                   ($urandom_range(0, 5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
